// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB arbiter sharing the ahb2apb bridge slave path.
// Holds ownership through fixed-length bursts and locked sequences.
`default_nettype none

module ahb_bus_arbiter #(
  parameter int NUM_MASTERS     = 4,
  parameter int MASTER_ID_WIDTH = 2,
  parameter int HBURST_WIDTH    = 3
) (
  input  logic                                 hclk_i,
  input  logic                                 hresetn_i,
  input  logic [NUM_MASTERS-1:0]               hbusreq_i,
  input  logic [NUM_MASTERS-1:0]               hlock_i,
  input  logic [NUM_MASTERS*HBURST_WIDTH-1:0]  hburst_i,
  input  logic [1:0]                           htrans_i,
  input  logic                                 hready_i,
  output logic [NUM_MASTERS-1:0]               hgrant_o,
  output logic [MASTER_ID_WIDTH-1:0]           hmaster_o,
  output logic                                 hmastlock_o,
  output logic                                 arb_busy_o
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ST_OPEN   = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                      state;
  logic [NUM_MASTERS-1:0]      grant;
  logic [MASTER_ID_WIDTH-1:0]  master;
  logic [MASTER_ID_WIDTH-1:0]  ptr;
  logic                        mastlock;
  logic [3:0]                  cnt;

  logic [HBURST_WIDTH-1:0]     owner_burst;
  logic                        burst_fixed;
  logic [3:0]                  burst_len_m1;
  logic                        is_seq;
  logic                        is_nonseq;
  logic                        is_idle;
  logic                        fixed_start;
  logic [3:0]                  cnt_locked_next;
  logic                        arb_now;
  logic                        arb_found;
  logic [MASTER_ID_WIDTH-1:0]  arb_winner;
  logic [MASTER_ID_WIDTH-1:0]  cand;

  always_comb begin
    owner_burst = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (master == MASTER_ID_WIDTH'(m))
        owner_burst = hburst_i[m*HBURST_WIDTH +: HBURST_WIDTH];
    end
  end

  always_comb begin
    burst_fixed  = 1'b1;
    burst_len_m1 = 4'd0;
    case (owner_burst)
      HBURST_WIDTH'(2), HBURST_WIDTH'(3): burst_len_m1 = 4'd3;
      HBURST_WIDTH'(4), HBURST_WIDTH'(5): burst_len_m1 = 4'd7;
      HBURST_WIDTH'(6), HBURST_WIDTH'(7): burst_len_m1 = 4'd15;
      default:                            burst_fixed  = 1'b0;
    endcase
  end

  // Round-robin scan starts just after the last winner and ends on it.
  always_comb begin
    arb_found  = 1'b0;
    arb_winner = master;
    cand       = ptr;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = MASTER_ID_WIDTH'((int'(ptr) + i) % NUM_MASTERS);
      if (!arb_found && hbusreq_i[cand]) begin
        arb_found  = 1'b1;
        arb_winner = cand;
      end
    end
  end

  always_comb begin
    is_seq      = (htrans_i == TRANS_SEQ);
    is_nonseq   = (htrans_i == TRANS_NONSEQ);
    is_idle     = (htrans_i == TRANS_IDLE);
    fixed_start = is_nonseq && burst_fixed;

    cnt_locked_next = cnt;
    if (fixed_start)
      cnt_locked_next = burst_len_m1;
    else if (is_nonseq || is_idle)
      cnt_locked_next = 4'd0;
    else if (is_seq && cnt != 4'd0)
      cnt_locked_next = cnt - 4'd1;

    case (state)
      ST_OPEN:   arb_now = !fixed_start;
      ST_BURST:  arb_now = (is_seq && cnt == 4'd1) || is_nonseq || is_idle;
      ST_LOCKED: arb_now = !hlock_i[master] && cnt_locked_next == 4'd0;
      default:   arb_now = 1'b1;
    endcase
  end

  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      state    <= ST_OPEN;
      grant    <= NUM_MASTERS'(1);
      master   <= '0;
      ptr      <= '0;
      mastlock <= 1'b0;
      cnt      <= 4'd0;
    end else if (hready_i) begin
      if (arb_now) begin
        grant    <= NUM_MASTERS'(1) << arb_winner;
        master   <= arb_winner;
        mastlock <= hlock_i[arb_winner];
        state    <= hlock_i[arb_winner] ? ST_LOCKED : ST_OPEN;
        cnt      <= 4'd0;
        if (arb_found)
          ptr <= arb_winner;
      end else begin
        case (state)
          // Only a fixed-burst NONSEQ suppresses arbitration in OPEN.
          ST_OPEN: begin
            cnt   <= burst_len_m1;
            state <= ST_BURST;
          end
          ST_BURST: begin
            if (is_seq)
              cnt <= cnt - 4'd1;
          end
          ST_LOCKED: cnt <= cnt_locked_next;
          default:   state <= ST_OPEN;
        endcase
      end
    end
  end

  assign hgrant_o    = grant;
  assign hmaster_o   = master;
  assign hmastlock_o = mastlock;
  assign arb_busy_o  = (state != ST_OPEN);

endmodule

`default_nettype wire

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed self-checking bench for ahb_bus_arbiter.
`default_nettype none

module tb_ahb_bus_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [3:0]  hbusreq;
  logic [3:0]  hlock;
  logic [11:0] hburst;
  logic [1:0]  htrans;
  logic        hready;
  logic [3:0]  hgrant;
  logic [1:0]  hmaster;
  logic        hmastlock;
  logic        arb_busy;

  int n_cmp = 0;
  int n_err = 0;

  ahb_bus_arbiter #(
    .NUM_MASTERS(4),
    .MASTER_ID_WIDTH(2),
    .HBURST_WIDTH(3)
  ) dut (
    .hclk_i     (hclk),
    .hresetn_i  (hresetn),
    .hbusreq_i  (hbusreq),
    .hlock_i    (hlock),
    .hburst_i   (hburst),
    .htrans_i   (htrans),
    .hready_i   (hready),
    .hgrant_o   (hgrant),
    .hmaster_o  (hmaster),
    .hmastlock_o(hmastlock),
    .arb_busy_o (arb_busy)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
    check("onehot", 32'($onehot(hgrant)), 32'd1);
  endtask

  task automatic set_burst(input int m, input logic [2:0] b);
    hburst[m*3 +: 3] = b;
  endtask

  task automatic expect_state(input string tag, input logic [3:0] g, input logic [1:0] m,
                              input logic lk, input logic bz);
    check({tag, ".grant"}, 32'(hgrant), 32'(g));
    check({tag, ".master"}, 32'(hmaster), 32'(m));
    check({tag, ".lock"}, 32'(hmastlock), 32'(lk));
    check({tag, ".busy"}, 32'(arb_busy), 32'(bz));
  endtask

  logic [1:0] wr_trans [11];
  logic       wr_ready [11];

  initial begin
    hresetn = 1'b0;
    hbusreq = '0;
    hlock   = '0;
    hburst  = '0;
    htrans  = IDLE;
    hready  = 1'b1;
    repeat (2) tick();
    expect_state("reset", 4'b0001, 2'd0, 1'b0, 1'b0);
    hresetn = 1'b1;

    // Round robin between masters 1 and 2 with SINGLE transfers.
    hbusreq = 4'b0110;
    htrans  = NONSEQ;
    tick(); expect_state("rr1", 4'b0010, 2'd1, 1'b0, 1'b0);
    tick(); expect_state("rr2", 4'b0100, 2'd2, 1'b0, 1'b0);
    tick(); expect_state("rr3", 4'b0010, 2'd1, 1'b0, 1'b0);
    tick(); expect_state("rr4", 4'b0100, 2'd2, 1'b0, 1'b0);

    // Master 1 INCR4 while master 3 waits.
    hbusreq = 4'b0010;
    htrans  = IDLE;
    tick(); expect_state("own1", 4'b0010, 2'd1, 1'b0, 1'b0);
    set_burst(1, 3'd3);
    hbusreq = 4'b1010;
    htrans  = NONSEQ;
    tick(); expect_state("incr4.b1", 4'b0010, 2'd1, 1'b0, 1'b1);
    htrans  = SEQ;
    tick(); expect_state("incr4.b2", 4'b0010, 2'd1, 1'b0, 1'b1);
    tick(); expect_state("incr4.b3", 4'b0010, 2'd1, 1'b0, 1'b1);
    tick(); expect_state("incr4.b4", 4'b1000, 2'd3, 1'b0, 1'b0);

    // Master 0 WRAP8 with BUSY and wait states mixed in.
    set_burst(1, 3'd0);
    hbusreq = 4'b0001;
    htrans  = IDLE;
    tick(); expect_state("own0", 4'b0001, 2'd0, 1'b0, 1'b0);
    set_burst(0, 3'd4);
    hbusreq = 4'b1011;
    htrans  = NONSEQ;
    tick(); expect_state("wrap8.b1", 4'b0001, 2'd0, 1'b0, 1'b1);
    wr_trans = '{SEQ, BUSY, SEQ, SEQ, SEQ, BUSY, SEQ, SEQ, SEQ, SEQ, SEQ};
    wr_ready = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 11; i++) begin
      htrans = wr_trans[i];
      hready = wr_ready[i];
      tick();
      expect_state($sformatf("wrap8.s%0d", i), 4'b0001, 2'd0, 1'b0, 1'b1);
    end
    htrans = SEQ;
    hready = 1'b1;
    tick(); expect_state("wrap8.b8", 4'b0010, 2'd1, 1'b0, 1'b0);

    // Master 2 locked INCR sequence, masters 0 and 3 waiting.
    set_burst(0, 3'd0);
    set_burst(2, 3'd1);
    hbusreq = 4'b1101;
    hlock   = 4'b0100;
    htrans  = IDLE;
    tick(); expect_state("lock.in", 4'b0100, 2'd2, 1'b1, 1'b1);
    htrans  = NONSEQ;
    tick(); expect_state("lock.ns", 4'b0100, 2'd2, 1'b1, 1'b1);
    htrans  = SEQ;
    tick(); expect_state("lock.s1", 4'b0100, 2'd2, 1'b1, 1'b1);
    hready  = 1'b0;
    hlock   = 4'b0000;
    tick(); expect_state("lock.wait", 4'b0100, 2'd2, 1'b1, 1'b1);
    hready  = 1'b1;
    tick(); expect_state("lock.out", 4'b1000, 2'd3, 1'b0, 1'b0);

    // Master 1 INCR16 cut short after 5 beats, master 2 waiting.
    set_burst(2, 3'd0);
    hbusreq = 4'b0010;
    htrans  = IDLE;
    tick(); expect_state("own1b", 4'b0010, 2'd1, 1'b0, 1'b0);
    set_burst(1, 3'd7);
    hbusreq = 4'b0110;
    htrans  = NONSEQ;
    tick();
    htrans  = SEQ;
    repeat (4) tick();
    expect_state("incr16.b5", 4'b0010, 2'd1, 1'b0, 1'b1);
    set_burst(1, 3'd0);
    htrans  = NONSEQ;
    tick(); expect_state("incr16.early", 4'b0100, 2'd2, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an INCR8 by master 2.
    set_burst(2, 3'd5);
    hbusreq = 4'b0100;
    htrans  = NONSEQ;
    tick();
    htrans  = SEQ;
    tick();
    tick(); expect_state("incr8.b3", 4'b0100, 2'd2, 1'b0, 1'b1);
    #2 hresetn = 1'b0;
    #1 expect_state("async_rst", 4'b0001, 2'd0, 1'b0, 1'b0);
    hbusreq = 4'b0000;
    htrans  = IDLE;
    #2 hresetn = 1'b1;
    tick(); expect_state("park", 4'b0001, 2'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Round-robin AHB bus arbiter and grant sequencer that shares the single AHB slave path into the ahb2apb bridge between NUM_MASTERS requesters.
- Tracks each owner's burst and decides when ownership may hand over: fixed-length bursts run to completion, and locked sequences are never interrupted.
- Drives the master-select for the address/data muxes in front of the bridge.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- MASTER_ID_WIDTH, 2, width of hmaster_o; equals ceil(log2(NUM_MASTERS)).
- HBURST_WIDTH, 3, width of each master's hburst field.

Ports:
- hclk_i  input  1  AHB clock; all state updates on its rising edge.
- hresetn_i  input  1  asynchronous active-low reset.
- hbusreq_i  input  NUM_MASTERS  per-master bus request, level.
- hlock_i  input  NUM_MASTERS  per-master lock request.
- hburst_i  input  NUM_MASTERS*HBURST_WIDTH  per-master burst type; master m occupies bits [m*3+2:m*3].
- htrans_i  input  2  htrans of the current owner, taken after the mux.
- hready_i  input  1  bus hready from the bridge.
- hgrant_o  output  NUM_MASTERS  one-hot grant.
- hmaster_o  output  MASTER_ID_WIDTH  index of the current address-phase owner.
- hmastlock_o  output  1  current owner holds a locked sequence.
- arb_busy_o  output  1  the owner is inside a fixed burst or a locked sequence.

Behaviour:
- Reset values: hgrant_o = 1 (master 0 parked), hmaster_o = 0, hmastlock_o = 0, arb_busy_o = 0, rr pointer = 0, beat counter = 0, state = OPEN.
- State machine with states OPEN, BURST and LOCKED. All registers are updated only on edges where hready_i = 1, except reset. hgrant_o, hmaster_o and hmastlock_o change together in the same cycle and are registered.
- Accepted beat: hready_i = 1 and htrans_i is NONSEQ (2'b10) or SEQ (2'b11). A BUSY (2'b01) or IDLE (2'b00) cycle is never counted.
- OPEN state:
  - An arbitration point exists on every hready_i = 1 edge, with one exception. If a NONSEQ is accepted with a fixed burst type for the owner (INCR4/WRAP4 = 4, INCR8/WRAP8 = 8, INCR16/WRAP16 = 16), load the beat counter with len-1 and go to BURST; no handover on that edge.
  - SINGLE and INCR stay in OPEN, so they may be re-arbitrated after any accepted beat.
- Arbitration:
  - Scan masters (ptr+1) mod N, ..., ptr. The first one with hbusreq_i set wins, and ptr is set to the winner.
  - If no request is pending, the grant stays with the current owner (park) and ptr is unchanged.
  - If the current owner still requests and no other master does, the owner keeps the grant.
- BURST state:
  - Each accepted SEQ decrements the counter.
  - On the accepted SEQ where counter == 1, the counter goes to 0, the state goes to OPEN and arbitration takes place on that same edge.
  - An accepted NONSEQ or an IDLE while in BURST is an early-terminated burst: the state returns to OPEN and arbitration takes place on that edge.
  - hbusreq_i deassertion by the owner during BURST is ignored.
- LOCKED state:
  - Entered on an arbitration edge where the selected winner has hlock_i set; hmastlock_o = 1 from that edge.
  - No re-arbitration occurs while hlock_i[owner] = 1. Fixed bursts inside LOCKED are counted but do not leave LOCKED.
  - On the first hready_i = 1 edge with hlock_i[owner] = 0 and no burst remaining, hmastlock_o goes to 0, the state goes to OPEN and arbitration takes place on that edge.
- arb_busy_o = 1 in BURST and LOCKED.
- Simultaneous events:
  - A request arriving on the same edge as a burst's last beat is included in that arbitration.
  - A lock arriving on a non-arbitration edge has no effect until the next arbitration point.
- Wait states: while hready_i = 0, all outputs and the counter hold.
- Reset mid-burst: asynchronous return to the reset values; any partial count is discarded.
- Invariant: hgrant_o is always exactly one-hot.

Test Plan:
- Reset, then masters 1 and 2 request continuously with SINGLE bursts and hready_i = 1 -> grant sequence 0 (parked), 1, 2, 1, 2; hmaster_o tracks it; arb_busy_o = 0 throughout.
- Master 1 owns the bus and issues INCR4: NONSEQ then 3 SEQ, with master 3 requesting -> the grant stays on 1 for 4 accepted beats. arb_busy_o = 1 from the NONSEQ until the 4th beat. hgrant_o = 4'b1000 on the edge the 4th beat is accepted.
- Master 0 issues WRAP8 with 2 BUSY cycles and 3 hready_i = 0 cycles interleaved -> the handover happens only after 8 accepted beats; the counter holds during BUSY and during wait states.
- Master 2 requests with hlock_i[2] = 1 and does SEQ beats of INCR, while masters 0 and 3 request -> hmastlock_o = 1 and the grant is held. On hlock_i[2] dropping with hready_i = 1, the grant goes to 3 and hmastlock_o = 0.
- Master 1 mid-INCR16 after 5 beats issues NONSEQ with SINGLE, while master 2 requests -> early termination, state OPEN, grant to master 2 on that edge.
- hresetn_i asserted low mid-INCR8 at beat 3 -> hgrant_o = 0001, hmaster_o = 0 and arb_busy_o = 0 immediately, without waiting for a clock edge.
